decode_execute_register: RTL
============================

DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of register operands, immediate and PC.
REQ-002 Parameter CNT_WIDTH, default 16, width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall_E  input  1  hold all E-stage contents this cycle.
REQ-006 flush_E  input  1  load a bubble into E stage this cycle.
REQ-007 valid_D  input  1  decode-stage instruction is valid.
REQ-008 ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D, ctrl_data_memory_WE_D, ctrl_result_D  input  1 each  decode-stage control bits.
REQ-009 ctrl_ALU_op_D  input  3  decode-stage ALU operation.
REQ-010 RD1_D, RD2_D, imm_D, PC_D  input  DATA_WIDTH each  operands, immediate, PC.
REQ-011 rs1_D, rs2_D, rd_D  input  5 each  source/destination register indices.
REQ-012 Outputs with the same names and widths, suffix _E, plus valid_E (1): registered E-stage copies.
REQ-013 hazard_load_use  output  1  load-use hazard request to stall decode.
REQ-014 bubble_count  output  CNT_WIDTH  number of bubbles inserted.

Function
REQ-015 Per-edge priority SHALL be: flush_E > stall_E > normal load.
REQ-016 Normal load (flush_E=0, stall_E=0): every _E register SHALL take its _D value; valid_E takes valid_D; latency exactly 1 cycle.
REQ-017 Stall (stall_E=1, flush_E=0): every _E register and valid_E SHALL hold its value.
REQ-018 Flush (flush_E=1, regardless of stall_E): valid_E and all ctrl_*_E SHALL be 0, ctrl_ALU_op_E = 3'b000, all data/index _E fields = 0.
REQ-019 A bubble SHALL be inert: ctrl_register_file_WE_E=0 and ctrl_data_memory_WE_E=0 whenever valid_E=0; a valid_D=0 load SHALL also force both write enables to 0.
REQ-020 bubble_count SHALL increment by 1 on each edge with flush_E=1, and on each normal-load edge with valid_D=0.
REQ-021 bubble_count SHALL saturate at all-ones and not wrap.
REQ-022 bubble_count SHALL not change on stall edges.
REQ-023 hazard_load_use SHALL be combinational from E registers and D inputs: valid_E & ctrl_result_E & ctrl_register_file_WE_E & valid_D & (rd_E != 0) & ((rd_E == rs1_D) | (rd_E == rs2_D)).
REQ-024 hazard_load_use SHALL be 0 when rd_E = 0, even if rs1_D or rs2_D = 0.
REQ-025 No output other than hazard_load_use SHALL have a combinational path from any input.

Reset
REQ-026 On rst=1, immediately and without a clock edge, all _E outputs, valid_E and bubble_count SHALL be 0.
REQ-027 rst SHALL override flush_E and stall_E; with rst held, outputs stay 0 across edges.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; first edge after release performs a normal load.

Verification
REQ-029 Load: valid_D=1, rd_D=5, RD1_D=0x12345678, ctrl_ALU_op_D=3'b010, no stall/flush -> next edge rd_E=5, RD1_E=0x12345678, ctrl_ALU_op_E=3'b010, valid_E=1.
REQ-030 Stall then flush: load PC_D=0x100; hold stall_E=1 3 cycles with PC_D=0x104 -> PC_E stays 0x100, bubble_count unchanged; then stall_E=1 with flush_E=1 -> PC_E=0, valid_E=0, bubble_count +1.
REQ-031 Load-use: E holds load (ctrl_result_E=1, WE_E=1, rd_E=7, valid_E=1), D has rs2_D=7, valid_D=1 -> hazard_load_use=1; rd_E=0 with rs1_D=0 -> hazard_load_use=0.
REQ-032 Saturation: CNT_WIDTH=4, flush_E=1 for 20 cycles -> bubble_count reaches 4'hF and holds at 4'hF.
REQ-033 Async reset: with valid_E=1 and bubble_count=3, pulse rst between clock edges -> all outputs 0 before the next edge; after release, normal load resumes.
REQ-034 Invalid decode: valid_D=0 with ctrl_register_file_WE_D=1, ctrl_data_memory_WE_D=1 -> after edge both write enables in E are 0, valid_E=0, bubble_count +1.

Source files
------------

// File: rtl/decode_execute_register.sv
// -----------------------------------------------------------------------------
// decode_execute_register
//
// Pipeline register between the decode (D) and execute (E) stages of an
// in-order core. Captures decoded control bits, operands, immediate, PC and
// register indices. Supports stall (hold), flush (insert bubble), counts the
// bubbles inserted, and raises a combinational load-use hazard request.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   stall_E, flush_E              hold / bubble-insert controls (flush wins)
//   valid_D, ctrl_*_D             decode-stage valid and control bits
//   ctrl_ALU_op_D [2:0]           decode-stage ALU operation
//   RD1_D, RD2_D, imm_D, PC_D     operands, immediate, PC   [DATA_WIDTH]
//   rs1_D, rs2_D, rd_D [4:0]      register indices
//   *_E, valid_E                  registered E-stage copies of the above
//   hazard_load_use               load-use stall request (combinational)
//   bubble_count [CNT_WIDTH]      saturating count of bubbles inserted
// -----------------------------------------------------------------------------
module decode_execute_register #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_E,
   input  logic                  flush_E,
   input  logic                  valid_D,
   input  logic                  ctrl_register_file_WE_D,
   input  logic                  ctrl_srcB_D,
   input  logic                  ctrl_register_file_WA_D,
   input  logic                  ctrl_data_memory_WE_D,
   input  logic                  ctrl_result_D,
   input  logic [2:0]            ctrl_ALU_op_D,
   input  logic [DATA_WIDTH-1:0] RD1_D,
   input  logic [DATA_WIDTH-1:0] RD2_D,
   input  logic [DATA_WIDTH-1:0] imm_D,
   input  logic [DATA_WIDTH-1:0] PC_D,
   input  logic [4:0]            rs1_D,
   input  logic [4:0]            rs2_D,
   input  logic [4:0]            rd_D,
   output logic                  valid_E,
   output logic                  ctrl_register_file_WE_E,
   output logic                  ctrl_srcB_E,
   output logic                  ctrl_register_file_WA_E,
   output logic                  ctrl_data_memory_WE_E,
   output logic                  ctrl_result_E,
   output logic [2:0]            ctrl_ALU_op_E,
   output logic [DATA_WIDTH-1:0] RD1_E,
   output logic [DATA_WIDTH-1:0] RD2_E,
   output logic [DATA_WIDTH-1:0] imm_E,
   output logic [DATA_WIDTH-1:0] PC_E,
   output logic [4:0]            rs1_E,
   output logic [4:0]            rs2_E,
   output logic [4:0]            rd_E,
   output logic                  hazard_load_use,
   output logic [CNT_WIDTH-1:0]  bubble_count
);

   // Stage payload kept as one struct so load/hold/flush act on all fields.
   typedef struct packed {
      logic                  valid;
      logic                  rf_we;
      logic                  srcb;
      logic                  rf_wa;
      logic                  dm_we;
      logic                  result;
      logic [2:0]            alu_op;
      logic [DATA_WIDTH-1:0] rd1;
      logic [DATA_WIDTH-1:0] rd2;
      logic [DATA_WIDTH-1:0] imm;
      logic [DATA_WIDTH-1:0] pc;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
   } stage_t;

   stage_t               r_stage;
   stage_t               w_load;
   logic [CNT_WIDTH-1:0] r_bubble_count;
   logic                 w_bubble_inc;
   logic                 w_cnt_sat;

   // Incoming payload; an invalid decode slot must never write anything.
   always_comb begin
      // NOTE: every field gets a value on every path, so no latch is inferred.
      w_load        = '0;
      w_load.valid  = valid_D;
      w_load.rf_we  = ctrl_register_file_WE_D & valid_D;
      w_load.srcb   = ctrl_srcB_D;
      w_load.rf_wa  = ctrl_register_file_WA_D;
      w_load.dm_we  = ctrl_data_memory_WE_D & valid_D;
      w_load.result = ctrl_result_D;
      w_load.alu_op = ctrl_ALU_op_D;
      w_load.rd1    = RD1_D;
      w_load.rd2    = RD2_D;
      w_load.imm    = imm_D;
      w_load.pc     = PC_D;
      w_load.rs1    = rs1_D;
      w_load.rs2    = rs2_D;
      w_load.rd     = rd_D;
   end

   // A bubble enters E on a flush, or on a normal load of an invalid slot.
   assign w_bubble_inc = flush_E | (~stall_E & ~valid_D);
   assign w_cnt_sat    = &r_bubble_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every register is reset here; there is no memory array whose
         // contents could be left unreset.
         r_stage        <= '0;
         r_bubble_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         if (flush_E) begin
            r_stage <= '0;
         end else if (!stall_E) begin
            r_stage <= w_load;
         end
         if (w_bubble_inc && !w_cnt_sat) begin
            r_bubble_count <= r_bubble_count + 1'b1;
         end
      end
   end

   assign valid_E                 = r_stage.valid;
   assign ctrl_register_file_WE_E = r_stage.rf_we;
   assign ctrl_srcB_E             = r_stage.srcb;
   assign ctrl_register_file_WA_E = r_stage.rf_wa;
   assign ctrl_data_memory_WE_E   = r_stage.dm_we;
   assign ctrl_result_E           = r_stage.result;
   assign ctrl_ALU_op_E           = r_stage.alu_op;
   assign RD1_E                   = r_stage.rd1;
   assign RD2_E                   = r_stage.rd2;
   assign imm_E                   = r_stage.imm;
   assign PC_E                    = r_stage.pc;
   assign rs1_E                   = r_stage.rs1;
   assign rs2_E                   = r_stage.rs2;
   assign rd_E                    = r_stage.rd;
   assign bubble_count            = r_bubble_count;

   // A load in E writing a nonzero register that the D instruction reads.
   // x0 is excluded, so rd_E=0 never matches even when rs1_D/rs2_D are 0.
   assign hazard_load_use = r_stage.valid & r_stage.result & r_stage.rf_we &
                            valid_D & (r_stage.rd != 5'd0) &
                            ((r_stage.rd == rs1_D) | (r_stage.rd == rs2_D));

endmodule
